// File: rtl/priority_encoder8x3_reg.sv
// ---------------------------------------------------------------------------
// priority_encoder8x3_reg
//   Registered 8-to-3 priority encoder with a pending-request register.
//   Request lines a0..a7 are collected into pend. The index of the
//   highest-priority pending bit is presented on x2..x0, qualified by valid.
//   An ack from the consumer releases the presented request.
//
// Parameters
//   HIGH_FIRST : 1 = a7 wins, 0 = a0 wins
//   STICKY     : 1 = requests latch until acknowledged
//                0 = pend follows the gated inputs every cycle, ack ignored
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         request capture enable
//   a0..a7     level-sensitive request lines
//   ack        consumer accepts the presented index (used only while valid)
//   x0,x1,x2   registered encoded index, x2 = MSB
//   valid      registered: at least one request pending
//   multi      registered: more than one request pending
// ---------------------------------------------------------------------------
module priority_encoder8x3_reg #(
   parameter bit HIGH_FIRST = 1'b1,
   parameter bit STICKY     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic a0,
   input  logic a1,
   input  logic a2,
   input  logic a3,
   input  logic a4,
   input  logic a5,
   input  logic a6,
   input  logic a7,
   input  logic ack,
   output logic x0,
   output logic x1,
   output logic x2,
   output logic valid,
   output logic multi
);

   logic [7:0] a_vec;
   logic [7:0] req;
   logic [7:0] clr;

   logic [7:0] pend_q,  pend_d;
   logic [2:0] x_q,     x_d;
   logic       valid_q, valid_d;
   logic       multi_q, multi_d;

   assign a_vec = {a7, a6, a5, a4, a3, a2, a1, a0};
   assign req   = en ? a_vec : 8'h00;

   // The clear mask is decoded from the index held before the edge, so an
   // ack always releases the request the consumer actually saw, even if a
   // higher-priority request shows up in the same cycle.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_clr
         assign clr[gi] = STICKY && valid_q && ack && (x_q == 3'(gi));
      end
   endgenerate

   always_comb begin
      pend_d  = 8'h00;
      x_d     = 3'd0;
      valid_d = 1'b0;
      multi_d = 1'b0;

      // Set beats clear: OR-ing req after masking keeps a re-requested bit.
      if (STICKY) begin
         pend_d = (pend_q & ~clr) | req;
      end else begin
         pend_d = req;
      end

      valid_d = |pend_d;
      // Clearing the lowest set bit leaves something only if >1 bit was set.
      multi_d = |(pend_d & (pend_d - 8'd1));

      // The last set bit visited wins, so the scan direction picks priority.
      if (HIGH_FIRST) begin
         for (int i = 0; i < 8; i++) begin
            if (pend_d[i]) x_d = 3'(i);
         end
      end else begin
         for (int i = 7; i >= 0; i--) begin
            if (pend_d[i]) x_d = 3'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q  <= 8'h00;
         x_q     <= 3'd0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         x_q     <= x_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
      end
   end

   assign x0    = x_q[0];
   assign x1    = x_q[1];
   assign x2    = x_q[2];
   assign valid = valid_q;
   assign multi = multi_q;

endmodule

// File: tb/tb_priority_encoder8x3_reg.sv
// ---------------------------------------------------------------------------
// tb_priority_encoder8x3_reg
//   Drives three encoder instances from one set of inputs:
//     inst 0: HIGH_FIRST=1 STICKY=1
//     inst 1: HIGH_FIRST=0 STICKY=1
//     inst 2: HIGH_FIRST=1 STICKY=0
//   A behavioural model tracks each instance; a compare process checks all
//   outputs on every falling edge, and directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_priority_encoder8x3_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic       ack = 1'b0;
   logic [7:0] a   = 8'h00;

   logic [2:0] dx0, dx1, dx2, dv, dm;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         priority_encoder8x3_reg #(
            .HIGH_FIRST(gi != 1),
            .STICKY    (gi != 2)
         ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .a0   (a[0]),
            .a1   (a[1]),
            .a2   (a[2]),
            .a3   (a[3]),
            .a4   (a[4]),
            .a5   (a[5]),
            .a6   (a[6]),
            .a7   (a[7]),
            .ack  (ack),
            .x0   (dx0[gi]),
            .x1   (dx1[gi]),
            .x2   (dx2[gi]),
            .valid(dv[gi]),
            .multi(dm[gi])
         );
      end
   endgenerate

   function automatic int get_x(int k);
      return {29'd0, dx2[k], dx1[k], dx0[k]};
   endfunction

   // ---------------- behavioural model ----------------
   logic [7:0] m_pend [3];
   int         m_x    [3];
   bit         m_v    [3];
   bit         m_mu   [3];

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_pend[k] = 8'h00; m_x[k] = 0; m_v[k] = 1'b0; m_mu[k] = 1'b0;
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         logic [7:0] p;
         bit hf, st;
         int cnt;
         hf = (k != 1);
         st = (k != 2);
         if (rst) begin
            p = 8'h00;
         end else begin
            if (st) begin
               p = m_pend[k];
               if (m_v[k] && ack) p[m_x[k]] = 1'b0;
               if (en) p = p | a;
            end else begin
               p = en ? a : 8'h00;
            end
         end
         m_pend[k] = p;
         cnt = 0;
         m_x[k] = 0;
         for (int i = 0; i < 8; i++) if (p[i]) cnt++;
         if (hf) begin
            for (int i = 0; i < 8; i++) if (p[i]) m_x[k] = i;
         end else begin
            for (int i = 7; i >= 0; i--) if (p[i]) m_x[k] = i;
         end
         m_v[k]  = (cnt > 0);
         m_mu[k] = (cnt > 1);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (checking) begin
         for (int k = 0; k < 3; k++) begin
            total++;
            if (get_x(k) != m_x[k] || dv[k] != m_v[k] || dm[k] != m_mu[k]) begin
               bad++;
               $display("FAIL model inst%0d: got x=%0d valid=%0b multi=%0b want x=%0d valid=%0b multi=%0b",
                        k, get_x(k), dv[k], dm[k], m_x[k], m_v[k], m_mu[k]);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end else begin
         $display("ok   %s: %0d", nm, act);
      end
   endtask

   initial begin
      // Reset held with all requests asserted.
      rst = 1'b1; en = 1'b1; a = 8'hFF; ack = 1'b0;
      tick(); tick();
      checking = 1'b1;
      chk("rst_x",     get_x(0), 0);
      chk("rst_valid", dv[0],    0);
      chk("rst_multi", dm[0],    0);
      rst = 1'b0;
      tick();
      chk("rel_x_hf",    get_x(0), 7);
      chk("rel_valid",   dv[0],    1);
      chk("rel_multi",   dm[0],    1);
      chk("rel_x_lf",    get_x(1), 0);
      // Mid-transaction reset discards everything.
      rst = 1'b1;
      tick();
      chk("midrst_valid", dv[0], 0);
      rst = 1'b0; a = 8'h00;
      tick();

      // Single request a5.
      a = 8'h20;
      tick();
      a = 8'h00;
      tick(); tick(); tick();
      chk("single_x",     get_x(0), 5);
      chk("single_valid", dv[0],    1);
      chk("single_multi", dm[0],    0);
      chk("single_st0",   dv[2],    0);
      ack = 1'b1;
      tick();
      chk("single_ack_valid", dv[0],    0);
      chk("single_ack_x",     get_x(0), 0);
      ack = 1'b0;
      tick();

      // Priority ordering a1, a4, a6.
      a = 8'h52;
      tick();
      a = 8'h00;
      chk("prio0_hf", get_x(0), 6);
      chk("prio0_lf", get_x(1), 1);
      ack = 1'b1;
      tick();
      chk("prio1_hf", get_x(0), 4);
      chk("prio1_lf", get_x(1), 4);
      tick();
      chk("prio2_hf", get_x(0), 1);
      chk("prio2_lf", get_x(1), 6);
      tick();
      chk("prio3_valid_hf", dv[0], 0);
      chk("prio3_valid_lf", dv[1], 0);
      ack = 1'b0;
      tick();

      // Held request re-captured over its own ack.
      a = 8'h08;
      tick();
      ack = 1'b1;
      tick();
      chk("hold_x",     get_x(0), 3);
      chk("hold_valid", dv[0],    1);
      tick();
      a = 8'h00;
      tick();
      chk("hold_rel_valid", dv[0], 0);
      ack = 1'b0;
      tick();

      // Higher request arrives in the same cycle as the ack of 2.
      a = 8'h04;
      tick();
      a = 8'h80; ack = 1'b1;
      tick();
      chk("race_x_hf",     get_x(0), 7);
      chk("race_multi_hf", dm[0],    0);
      chk("race_x_lf",     get_x(1), 7);
      chk("race_multi_lf", dm[1],    0);
      a = 8'h00;
      tick();
      chk("race_done", dv[0], 0);
      ack = 1'b0;

      // Enable gating.
      en = 1'b0; a = 8'h01;
      tick();
      chk("en0_valid", dv[0], 0);
      en = 1'b1; a = 8'h00;
      tick();
      chk("en1_noreq_valid", dv[0], 0);
      a = 8'h30;
      tick();
      en = 1'b0; a = 8'h00; ack = 1'b1;
      tick();
      chk("en0_ack_x",     get_x(0), 4);
      chk("en0_ack_valid", dv[0],    1);
      chk("en0_ack_lf_x",  get_x(1), 5);
      tick();
      chk("en0_ack_done", dv[0], 0);
      ack = 1'b0; en = 1'b1;
      tick();

      // Non-sticky mirroring; ack must not matter.
      a = 8'h24;
      tick();
      chk("st0_c1_x",     get_x(2), 5);
      chk("st0_c1_multi", dm[2],    1);
      ack = 1'b1;
      tick();
      chk("st0_c2_x",     get_x(2), 5);
      chk("st0_c2_valid", dv[2],    1);
      a = 8'h00; ack = 1'b0;
      tick();
      chk("st0_c3_valid", dv[2], 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Full drain plus a few mixed vectors checked by the model.
      a = 8'hFF;
      tick();
      a = 8'h00; ack = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      chk("drain_valid", dv[0], 0);
      ack = 1'b0;
      for (int i = 0; i < 12; i++) begin
         a   = 8'(i * 37 + 5);
         en  = (i % 4) != 3;
         ack = i[0];
         tick();
      end
      a = 8'h00; ack = 1'b0; en = 1'b1;
      tick();
      @(negedge clk);
      #1;
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/priority_encoder8x3_reg.md
Name: priority_encoder8x3_reg

Overview:
- Registered 8-to-3 priority encoder; the inverse of the 3x8 decoder.
- Collects eight request lines a0..a7 into a pending register.
- Presents the index of the highest-priority pending request on x2..x0, qualified by valid.
- Releases that request when the consumer pulses ack; used to turn one-hot/multi-hot event lines back into a binary select for the decoder side.

Parameters:
- HIGH_FIRST, 1: 1 = a7 has highest priority; 0 = a0 has highest priority.
- STICKY, 1: 1 = requests latch into pending until acknowledged; 0 = pending mirrors the current inputs each cycle and ack is ignored.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en   input  1  request enable; when 0, new requests are not captured.
- a0..a7  input  1 each  request lines, level-sensitive, sampled every rising edge.
- ack  input  1  consumer accepts the currently presented index; meaningful only when valid=1.
- x0, x1, x2  output  1 each  encoded index (x2 = MSB); registered.
- valid  output  1  at least one request pending; registered.
- multi  output  1  more than one request pending; registered.

Behaviour:
- Internal state: pend[7:0]. Outputs x2..x0, valid and multi are all registers.
- Reset (rst=1 at a rising edge): pend=0, x2..x0=000, valid=0, multi=0. Reset overrides en, a*, ack; asserting it mid-transaction discards all pending requests.
- Capture mask: req = {a7..a0} when en=1, else 8'h00.
- Clear mask: clr = one-hot(x2..x0) when STICKY=1 and valid=1 and ack=1, else 8'h00.
- Next state, STICKY=1: pend_n = (pend & ~clr) | req. Set beats clear: if the acknowledged bit is re-requested in the same cycle, it stays pending.
- Next state, STICKY=0: pend_n = req; ack has no effect.
- Outputs are computed from pend_n and registered in the same edge as pend:
  - valid = |pend_n.
  - multi = more than one bit of pend_n set.
  - x = index of the highest-priority set bit of pend_n (priority per HIGH_FIRST); x = 000 when pend_n = 0.
- Latency:
  - Request asserted before edge k: valid and x reflect it after edge k (1 cycle).
  - Ack sampled at edge k: the next index is presented after edge k. Back-to-back service, no bubble cycles.
- Ack while valid=0: ignored, no state change.
- Ack is taken against the x value held before the edge. If a higher-priority request arrives in the same cycle as the ack, the acknowledged (lower) bit is still the one cleared, and x switches to the new higher index.
- en=0: pending contents hold; ack still clears bits. With STICKY=0, en=0 forces pend to 0.
- All 8 bits pending: service order is 7,6,...,0 (HIGH_FIRST=1) or 0..7 (HIGH_FIRST=0); one index per acked cycle.
- A request held high continuously is re-captured every cycle, so it reappears immediately after its ack. The consumer must deassert the request or accept repeat service.

Test Plan:
- Reset: rst=1 for 2 cycles with a*=8'hFF, en=1 → x=000, valid=0, multi=0. Release rst → after next edge x=111, valid=1, multi=1.
- Single request: pulse a5 for 1 cycle, en=1, ack=0 → x=101, valid=1, multi=0, held indefinitely. Pulse ack → after that edge valid=0, x=000.
- Priority ordering: pulse a1, a4, a6 together → x=110. Ack each cycle → x sequence 110, 100, 001, then valid=0. With HIGH_FIRST=0 the sequence is 001, 100, 110.
- Simultaneous events:
  - Hold a3 high while acking index 3 → valid stays 1, x stays 011.
  - With only a2 pending, assert a7 in the same cycle as the ack of 2 → x=111 next, bit 2 cleared.
- Enable gating: en=0, pulse a0 → valid stays 0. Set en=1 with no requests → valid stays 0. Existing pending bits still clear on ack while en=0.
- STICKY=0: drive a*=8'b0010_0100 for 2 cycles then 0 → x=101, valid=1, multi=1 for exactly 2 cycles, then valid=0. Ack has no effect throughout.
